// File: rtl/ram_ctrl_pkg.sv
// Shared types and sizes for the RAM fill/check controller.
// Covers the 32 x 3 two-port RAM and the data pattern the engine writes into it.
package ram_ctrl_pkg;

    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int DW    = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        CHECK = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } ctrl_state_t;

    // Word value the engine writes, and later expects back, at a given address.
    function automatic logic [DW-1:0] fill_value(input logic [DW-1:0] seed,
                                                 input logic [DW-1:0] addr_lo);
        return seed ^ addr_lo;
    endfunction

endpackage

// File: rtl/ram_fill_check_ctrl_exp_pipe.sv
// Expected-data delay line that lines check-phase expectations up with RAM read data.
// Each stage holds {valid, expected}.
module exp_pipe
    import ram_ctrl_pkg::*;
#(
    parameter int DEPTH_P = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [DW-1:0] in_exp,
    output logic          out_valid,
    output logic [DW-1:0] out_exp
);

    logic [DW:0] stage_r [DEPTH_P];

    // Shift register; reset clears every stage so no stale valid bits survive an abort.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_P; i++) begin
                stage_r[i] <= {(DW+1){1'b0}};
            end
        end else begin
            stage_r[0] <= {in_valid, in_exp};
            for (int i = 1; i < DEPTH_P; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign out_valid = stage_r[DEPTH_P-1][DW];
    assign out_exp   = stage_r[DEPTH_P-1][DW-1:0];

endmodule

// File: rtl/ram_fill_check_ctrl.sv
// Fill/check sequencer sharing one 32x3 two-port RAM with a host port.
// In IDLE the host drives the RAM directly; otherwise the engine owns it.
module ram_fill_check_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int RD_LATENCY = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [DW-1:0] pattern,
    output logic          busy,
    output logic          done,
    output logic [5:0]    errors,
    input  logic          host_wren,
    input  logic [AW-1:0] host_wraddress,
    input  logic [DW-1:0] host_data,
    input  logic [AW-1:0] host_rdaddress,
    output logic [DW-1:0] host_q,
    output logic          ram_wren,
    output logic [AW-1:0] ram_wraddress,
    output logic [AW-1:0] ram_rdaddress,
    output logic [DW-1:0] ram_data,
    input  logic [DW-1:0] ram_q
);

    localparam int DCW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(RD_LATENCY - 1);
    localparam logic [AW-1:0]  LAST_ADDR  = AW'(DEPTH - 1);

    ctrl_state_t    state_r;
    logic [AW-1:0]  addr_cnt_r;
    logic [DW-1:0]  seed_r;
    logic [DCW-1:0] drain_cnt_r;
    logic [5:0]     errors_r;
    logic           busy_r;
    logic           done_r;

    logic [DW-1:0]  exp_s;
    logic           push_valid_s;
    logic           pipe_valid_s;
    logic [DW-1:0]  pipe_exp_s;
    logic           cmp_hit_s;

    assign exp_s        = fill_value(seed_r, addr_cnt_r[DW-1:0]);
    assign push_valid_s = (state_r == CHECK);

    exp_pipe #(
        .DEPTH_P (RD_LATENCY)
    ) u_exp_pipe (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (push_valid_s),
        .in_exp    (exp_s),
        .out_valid (pipe_valid_s),
        .out_exp   (pipe_exp_s)
    );

    // A mismatch counts only while the engine is reading back its own pattern.
    always_comb begin
        cmp_hit_s = 1'b0;
        if ((state_r == CHECK || state_r == DRAIN) && pipe_valid_s && (ram_q != pipe_exp_s)) begin
            cmp_hit_s = 1'b1;
        end else begin
            cmp_hit_s = 1'b0;
        end
    end

    // Run sequencer with its registered status outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= IDLE;
            addr_cnt_r  <= {AW{1'b0}};
            seed_r      <= {DW{1'b0}};
            drain_cnt_r <= {DCW{1'b0}};
            errors_r    <= 6'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (cmp_hit_s) begin
                errors_r <= errors_r + 6'd1;
            end
            case (state_r)
                IDLE: begin
                    if (start) begin
                        seed_r     <= pattern;
                        errors_r   <= 6'd0;
                        addr_cnt_r <= {AW{1'b0}};
                        busy_r     <= 1'b1;
                        state_r    <= FILL;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                FILL: begin
                    addr_cnt_r <= addr_cnt_r + 5'd1;
                    if (addr_cnt_r == LAST_ADDR) begin
                        state_r <= CHECK;
                    end
                end
                CHECK: begin
                    addr_cnt_r <= addr_cnt_r + 5'd1;
                    if (addr_cnt_r == LAST_ADDR) begin
                        drain_cnt_r <= DRAIN_LOAD;
                        state_r     <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_cnt_r == {DCW{1'b0}}) begin
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        drain_cnt_r <= drain_cnt_r - DCW'(1);
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // RAM port ownership: host in IDLE, engine otherwise (host writes are dropped).
    always_comb begin
        ram_wren      = 1'b0;
        ram_wraddress = {AW{1'b0}};
        ram_rdaddress = {AW{1'b0}};
        ram_data      = {DW{1'b0}};
        if (state_r == IDLE) begin
            ram_wren      = host_wren;
            ram_wraddress = host_wraddress;
            ram_rdaddress = host_rdaddress;
            ram_data      = host_data;
        end else begin
            ram_wren      = (state_r == FILL);
            ram_wraddress = addr_cnt_r;
            ram_rdaddress = addr_cnt_r;
            ram_data      = exp_s;
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign errors = errors_r;
    assign host_q = ram_q;

endmodule

// File: tb/tb_ram_fill_check_ctrl.sv
// Randomized scoreboard bench for ram_fill_check_ctrl with a behavioural two-port RAM.
// The RAM model can corrupt its read data to emulate faulty memory.
module tb_ram_fill_check_ctrl;

    localparam int L = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [2:0] pattern = 3'd0;
    logic       busy;
    logic       done;
    logic [5:0] errors;
    logic       host_wren = 1'b0;
    logic [4:0] host_wraddress = 5'd0;
    logic [2:0] host_data = 3'd0;
    logic [4:0] host_rdaddress = 5'd0;
    logic [2:0] host_q;
    logic       ram_wren;
    logic [4:0] ram_wraddress;
    logic [4:0] ram_rdaddress;
    logic [2:0] ram_data;
    logic [2:0] ram_q;

    always #5 clock = ~clock;

    ram_fill_check_ctrl #(.RD_LATENCY(L)) dut (
        .clock(clock), .reset(reset), .start(start), .pattern(pattern),
        .busy(busy), .done(done), .errors(errors),
        .host_wren(host_wren), .host_wraddress(host_wraddress), .host_data(host_data),
        .host_rdaddress(host_rdaddress), .host_q(host_q),
        .ram_wren(ram_wren), .ram_wraddress(ram_wraddress), .ram_rdaddress(ram_rdaddress),
        .ram_data(ram_data), .ram_q(ram_q)
    );

    // Read-data corruption: 1 flips bit0 at words 7 and 20, 2 is stuck at zero.
    function automatic logic [2:0] fault_q(int mode, logic [4:0] a, logic [2:0] v);
        if (mode == 1) return (a == 5'd7 || a == 5'd20) ? (v ^ 3'b001) : v;
        if (mode == 2) return 3'b000;
        return v;
    endfunction

    // RAM model: registered read address plus registered output.
    int         fault_mode = 0;
    logic [2:0] mem [32];
    logic [4:0] rd_addr_r = 5'd0;
    logic [2:0] q_r = 3'd0;
    initial for (int i = 0; i < 32; i++) mem[i] = 3'd0;
    always @(posedge clock) begin
        if (ram_wren) mem[ram_wraddress] <= ram_data;
        rd_addr_r <= ram_rdaddress;
        q_r <= fault_q(fault_mode, rd_addr_r, mem[rd_addr_r]);
    end
    assign ram_q = q_r;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errs = 0;

    typedef struct { int err; int due; } run_exp_t;
    typedef struct { logic [2:0] val; int due; } rd_exp_t;
    run_exp_t done_q[$];
    rd_exp_t  read_q[$];
    run_exp_t mon_run;
    rd_exp_t  mon_rd;

    logic [2:0] mem_ref [32];
    bit         mem_known [32];
    int         last_err = 0;

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Reference mismatch count: every word holds p ^ addr[2:0]; count the reads the fault alters.
    function automatic int ref_errors(logic [2:0] p, int mode);
        int n = 0;
        for (int a = 0; a < 32; a++) begin
            logic [2:0] v = p ^ 3'(a);
            if (fault_q(mode, 5'(a), v) != v) n++;
        end
        return n;
    endfunction

    // Monitor: pops the scoreboard whenever done pulses or a host read is due.
    always @(negedge clock) begin
        if (done) begin
            if (done_q.size() == 0) begin
                checks++;
                errs++;
                $display("FAIL spurious_done at cycle %0d: got done=1 expected none", cyc);
            end else begin
                mon_run = done_q.pop_front();
                check("done_errors", int'(errors), mon_run.err);
                check("done_cycle", cyc, mon_run.due);
            end
        end
        if (read_q.size() > 0 && read_q[0].due == cyc) begin
            mon_rd = read_q.pop_front();
            check("host_q", int'(host_q), int'(mon_rd.val));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic host_write(logic [4:0] a, logic [2:0] d);
        host_wren = 1'b1;
        host_wraddress = a;
        host_data = d;
        tick();
        host_wren = 1'b0;
        mem_ref[a] = d;
        mem_known[a] = 1'b1;
    endtask

    task automatic host_read(logic [4:0] a);
        rd_exp_t r;
        host_rdaddress = a;
        r.val = fault_q(fault_mode, a, mem_ref[a]);
        r.due = cyc + L;
        read_q.push_back(r);
        repeat (L + 1) tick();
    endtask

    task automatic start_run(logic [2:0] p, int mode, bit completes);
        run_exp_t e;
        fault_mode = mode;
        pattern = p;
        start = 1'b1;
        if (completes) begin
            e.err = ref_errors(p, mode);
            e.due = cyc + 65 + L;
            done_q.push_back(e);
            last_err = e.err;
        end
        tick();
        start = 1'b0;
        pattern = 3'($urandom_range(7));
        check("busy_after_start", int'(busy), 1);
        for (int a = 0; a < 32; a++) begin
            mem_ref[a] = p ^ 3'(a);
            mem_known[a] = completes;
        end
    endtask

    task automatic wait_drain(int bound);
        int n = 0;
        while ((done_q.size() > 0 || read_q.size() > 0) && n < bound) begin
            tick();
            n++;
        end
        checks++;
        if (n >= bound) begin
            errs++;
            $display("FAIL wait_timeout at cycle %0d: got %0d pending expected 0",
                     cyc, done_q.size() + read_q.size());
            done_q.delete();
            read_q.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog at cycle %0d: got no finish expected finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] p;
        logic [4:0] a;
        int mode;
        int due1;
        run_exp_t e;

        for (int i = 0; i < 32; i++) mem_known[i] = 1'b0;

        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_errors", int'(errors), 0);

        host_wren = 1'b1;
        host_wraddress = 5'd5;
        host_data = 3'b101;
        #1;
        check("idle_pass_wren", int'(ram_wren), 1);
        check("idle_pass_wraddr", int'(ram_wraddress), 5);
        tick();
        host_wren = 1'b0;
        mem_ref[5] = 3'b101;
        mem_known[5] = 1'b1;
        host_read(5'd5);

        // Clean run with pattern 110; word 3 must read back 101.
        start_run(3'b110, 0, 1'b1);
        wait_drain(200);
        host_read(5'd3);
        check("word3_clean", int'(mem_ref[3]), int'(3'b101));
        repeat (5) tick();
        check("errors_hold", int'(errors), last_err);

        // Host write and second start during FILL must both be ignored.
        start_run(3'b011, 0, 1'b1);
        repeat (8) tick();
        host_wren = 1'b1;
        host_wraddress = 5'd0;
        host_data = 3'b000;
        start = 1'b1;
        pattern = 3'b100;
        tick();
        host_wren = 1'b0;
        start = 1'b0;
        check("busy_blocking", int'(busy), 1);
        wait_drain(200);
        repeat (80) tick();
        host_read(5'd0);

        // Faulty RAM models.
        start_run(3'($urandom_range(7)), 1, 1'b1);
        wait_drain(200);
        start_run(3'b111, 2, 1'b1);
        wait_drain(200);

        // Reset in CHECK after some mismatches have accumulated.
        start_run(3'b111, 2, 1'b0);
        repeat (38) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrun_busy", int'(busy), 0);
        check("midrun_errors", int'(errors), 0);
        repeat (80) tick();
        start_run(3'b010, 0, 1'b1);
        wait_drain(200);

        // start held high re-triggers one cycle after DONE.
        fault_mode = 1;
        pattern = 3'b001;
        start = 1'b1;
        e.err = ref_errors(3'b001, 1);
        e.due = cyc + 65 + L;
        due1 = e.due;
        done_q.push_back(e);
        e.due = due1 + 66 + L;
        done_q.push_back(e);
        while (cyc < due1 + 2) tick();
        start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            mem_ref[i] = 3'b001 ^ 3'(i);
            mem_known[i] = 1'b1;
        end
        wait_drain(300);

        // Randomized host traffic interleaved with runs.
        for (int it = 0; it < 4; it++) begin
            fault_mode = 0;
            for (int w = 0; w < 3; w++) begin
                host_write(5'($urandom_range(31)), 3'($urandom_range(7)));
            end
            a = host_wraddress;
            host_read(a);
            p = 3'($urandom_range(7));
            mode = $urandom_range(2);
            start_run(p, mode, 1'b1);
            wait_drain(200);
            for (int r = 0; r < 2; r++) begin
                a = 5'($urandom_range(31));
                if (mem_known[a]) host_read(a);
            end
        end
        wait_drain(50);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
